// File: rtl/spinnaker_fpgas_reg_arbiter.sv
// spinnaker_fpgas_reg_arbiter
//
// Two-master arbiter for a single register bank. Each access takes three
// cycles: IDLE (grant and capture), ACCESS (bank cycle) and DONE (ack).
//
// Configuration macro:
//   REG_ARB_ROUND_ROBIN_EN  defined   -> round-robin between the two masters
//                           undefined -> fixed priority, master 0 always wins
//
// Ports:
//   CLK_IN, RESET_IN             clock, synchronous active-high reset
//   Mn_REQ_IN                    request from master n, held until its ack
//   Mn_WRITE_IN                  1 = write, 0 = read
//   Mn_ADDR_IN, Mn_WRITE_DATA_IN access address and write data
//   Mn_ACK_OUT                   one-cycle completion pulse to master n
//   Mn_READ_DATA_OUT             read result, held until master n's next access
//   WRITE_OUT                    bank write strobe (high only in ACCESS)
//   ADDR_OUT, WRITE_DATA_OUT     bank address and write data
//   READ_DATA_IN                 combinational bank read data for ADDR_OUT
//   BUSY_OUT                     high whenever the FSM is not in IDLE
module spinnaker_fpgas_reg_arbiter #(
    parameter int unsigned REGA_BITS = 14,
    parameter int unsigned REGD_BITS = 32
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_IN,

    input  logic                 M0_REQ_IN,
    input  logic                 M0_WRITE_IN,
    input  logic [REGA_BITS-1:0] M0_ADDR_IN,
    input  logic [REGD_BITS-1:0] M0_WRITE_DATA_IN,
    output logic                 M0_ACK_OUT,
    output logic [REGD_BITS-1:0] M0_READ_DATA_OUT,

    input  logic                 M1_REQ_IN,
    input  logic                 M1_WRITE_IN,
    input  logic [REGA_BITS-1:0] M1_ADDR_IN,
    input  logic [REGD_BITS-1:0] M1_WRITE_DATA_IN,
    output logic                 M1_ACK_OUT,
    output logic [REGD_BITS-1:0] M1_READ_DATA_OUT,

    output logic                 WRITE_OUT,
    output logic [REGA_BITS-1:0] ADDR_OUT,
    output logic [REGD_BITS-1:0] WRITE_DATA_OUT,
    input  logic [REGD_BITS-1:0] READ_DATA_IN,

    output logic                 BUSY_OUT
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e               state_q;
    logic                 grant_q;      // 0 = master 0, 1 = master 1
    logic                 write_q;
    logic [REGA_BITS-1:0] addr_q;
    logic [REGD_BITS-1:0] wdata_q;
    logic                 ack0_q;
    logic                 ack1_q;
    logic [REGD_BITS-1:0] rdata0_q;
    logic [REGD_BITS-1:0] rdata1_q;
    logic                 busy_q;
    logic                 sel_m1;       // grant decision, only meaningful in IDLE

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic                 last_q;       // master granted most recently

    // On contention hand the bank to whichever master was not served last.
    always_comb begin
        sel_m1 = M1_REQ_IN;
        if (M0_REQ_IN && M1_REQ_IN) begin
            sel_m1 = ~last_q;
        end
    end
`else
    always_comb begin
        sel_m1 = ~M0_REQ_IN;
    end
`endif

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            // Strobe and acks are single-cycle pulses unless set below.
            write_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (M0_REQ_IN || M1_REQ_IN) begin
                        grant_q <= sel_m1;
                        write_q <= sel_m1 ? M1_WRITE_IN      : M0_WRITE_IN;
                        addr_q  <= sel_m1 ? M1_ADDR_IN       : M0_ADDR_IN;
                        wdata_q <= sel_m1 ? M1_WRITE_DATA_IN : M0_WRITE_DATA_IN;
                        busy_q  <= 1'b1;
                        state_q <= StAccess;
`ifdef REG_ARB_ROUND_ROBIN_EN
                        last_q  <= sel_m1;
`endif
                    end
                end
                StAccess: begin
                    // Read data is captured for writes too; it is simply the
                    // bank contents seen during the write cycle.
                    if (grant_q) begin
                        rdata1_q <= READ_DATA_IN;
                        ack1_q   <= 1'b1;
                    end else begin
                        rdata0_q <= READ_DATA_IN;
                        ack0_q   <= 1'b1;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign WRITE_OUT        = write_q;
    assign ADDR_OUT         = addr_q;
    assign WRITE_DATA_OUT   = wdata_q;
    assign M0_ACK_OUT       = ack0_q;
    assign M1_ACK_OUT       = ack1_q;
    assign M0_READ_DATA_OUT = rdata0_q;
    assign M1_READ_DATA_OUT = rdata1_q;
    assign BUSY_OUT         = busy_q;

endmodule

// File: tb/tb_spinnaker_fpgas_reg_arbiter.sv
// Bench for spinnaker_fpgas_reg_arbiter: a 4-word register bank model sits
// behind the arbiter; expected acks (master, read data, cycle) are queued when
// a request is driven and popped as acks appear.
module tb_spinnaker_fpgas_reg_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;

    logic          CLK_IN = 1'b0;
    logic          RESET_IN;
    logic          M0_REQ_IN, M0_WRITE_IN, M0_ACK_OUT;
    logic [AW-1:0] M0_ADDR_IN;
    logic [DW-1:0] M0_WRITE_DATA_IN, M0_READ_DATA_OUT;
    logic          M1_REQ_IN, M1_WRITE_IN, M1_ACK_OUT;
    logic [AW-1:0] M1_ADDR_IN;
    logic [DW-1:0] M1_WRITE_DATA_IN, M1_READ_DATA_OUT;
    logic          WRITE_OUT, BUSY_OUT;
    logic [AW-1:0] ADDR_OUT;
    logic [DW-1:0] WRITE_DATA_OUT, READ_DATA_IN;

    always #5 CLK_IN = ~CLK_IN;

    spinnaker_fpgas_reg_arbiter #(.REGA_BITS(AW), .REGD_BITS(DW)) dut (
        .CLK_IN           (CLK_IN),
        .RESET_IN         (RESET_IN),
        .M0_REQ_IN        (M0_REQ_IN),
        .M0_WRITE_IN      (M0_WRITE_IN),
        .M0_ADDR_IN       (M0_ADDR_IN),
        .M0_WRITE_DATA_IN (M0_WRITE_DATA_IN),
        .M0_ACK_OUT       (M0_ACK_OUT),
        .M0_READ_DATA_OUT (M0_READ_DATA_OUT),
        .M1_REQ_IN        (M1_REQ_IN),
        .M1_WRITE_IN      (M1_WRITE_IN),
        .M1_ADDR_IN       (M1_ADDR_IN),
        .M1_WRITE_DATA_IN (M1_WRITE_DATA_IN),
        .M1_ACK_OUT       (M1_ACK_OUT),
        .M1_READ_DATA_OUT (M1_READ_DATA_OUT),
        .WRITE_OUT        (WRITE_OUT),
        .ADDR_OUT         (ADDR_OUT),
        .WRITE_DATA_OUT   (WRITE_DATA_OUT),
        .READ_DATA_IN     (READ_DATA_IN),
        .BUSY_OUT         (BUSY_OUT)
    );

    // Register bank model, reinitialised on reset.
    logic [DW-1:0] bank [4];
    always @(posedge CLK_IN) begin
        if (RESET_IN) begin
            bank[0] <= 32'hCAFEF00D;
            bank[1] <= 32'h11111111;
            bank[2] <= 32'h22222222;
            bank[3] <= 32'h33333333;
        end else if (WRITE_OUT) begin
            bank[ADDR_OUT[1:0]] <= WRITE_DATA_OUT;
        end
    end
    assign READ_DATA_IN = bank[ADDR_OUT[1:0]];

    typedef struct {
        int            m;
        logic [DW-1:0] rd;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ncyc    = 0;

    task automatic tick();
        @(negedge CLK_IN);
        ncyc++;
    endtask

    task automatic idle_inputs();
        M0_REQ_IN = 0; M0_WRITE_IN = 0; M0_ADDR_IN = '0; M0_WRITE_DATA_IN = '0;
        M1_REQ_IN = 0; M1_WRITE_IN = 0; M1_ADDR_IN = '0; M1_WRITE_DATA_IN = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET_IN = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({WRITE_OUT, M0_ACK_OUT, M1_ACK_OUT, BUSY_OUT} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: wr/ack0/ack1/busy=%b required 0000",
                     {WRITE_OUT, M0_ACK_OUT, M1_ACK_OUT, BUSY_OUT});
        end
        n_tests++;
        if (ADDR_OUT !== '0 || WRITE_DATA_OUT !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", ADDR_OUT, WRITE_DATA_OUT);
        end
        n_tests++;
        if (M0_READ_DATA_OUT !== '0 || M1_READ_DATA_OUT !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: rd0=%h rd1=%h required 0/0",
                     M0_READ_DATA_OUT, M1_READ_DATA_OUT);
        end
        RESET_IN = 1'b0;
    endtask

    task automatic test_write();
        int start, wr, m;
        logic [DW-1:0] rd;
        exp_t e;
        start = ncyc;
        wr = 0;
        M0_REQ_IN = 1; M0_WRITE_IN = 1; M0_ADDR_IN = 14'd2; M0_WRITE_DATA_IN = 32'h12345678;
        exp_q.push_back('{0, 32'h22222222, start + 2});
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ncyc == start + 1) begin
                n_tests++;
                if (BUSY_OUT !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_busy: busy=%b required 1", BUSY_OUT);
                end
            end
            if (WRITE_OUT) begin
                wr++;
                n_tests++;
                if (ADDR_OUT !== 14'd2 || WRITE_DATA_OUT !== 32'h12345678) begin
                    n_fail++;
                    $display("FAIL write_bus: addr=%h data=%h required 0002/12345678",
                             ADDR_OUT, WRITE_DATA_OUT);
                end
            end
            if (M0_ACK_OUT || M1_ACK_OUT) begin
                m = M1_ACK_OUT ? 1 : 0;
                rd = M1_ACK_OUT ? M1_READ_DATA_OUT : M0_READ_DATA_OUT;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_ack: got M%0d ack at %0d required none", m, ncyc);
                end else begin
                    e = exp_q.pop_front();
                    if (m != e.m || rd !== e.rd || ncyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL write_ack: got M%0d rd=%h cyc=%0d required M%0d rd=%h cyc=%0d",
                                 m, rd, ncyc, e.m, e.rd, e.cyc);
                    end
                end
                if (M0_ACK_OUT) M0_REQ_IN = 0;
            end
        end
        n_tests++;
        if (wr != 1) begin
            n_fail++;
            $display("FAIL write_strobe_count: got %0d required 1", wr);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_ack_missing: %0d acks outstanding required 0", exp_q.size());
        end
        exp_q.delete();
        n_tests++;
        if (bank[2] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_bank: bank[2]=%h required 12345678", bank[2]);
        end
    endtask

    task automatic test_read();
        int start, wr, m;
        logic [DW-1:0] rd;
        exp_t e;
        start = ncyc;
        wr = 0;
        M1_REQ_IN = 1; M1_WRITE_IN = 0; M1_ADDR_IN = 14'd0; M1_WRITE_DATA_IN = 32'h55555555;
        exp_q.push_back('{1, 32'hCAFEF00D, start + 2});
        for (int i = 0; i < 8; i++) begin
            tick();
            if (WRITE_OUT) wr++;
            if (M0_ACK_OUT || M1_ACK_OUT) begin
                m = M1_ACK_OUT ? 1 : 0;
                rd = M1_ACK_OUT ? M1_READ_DATA_OUT : M0_READ_DATA_OUT;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_ack: got M%0d ack at %0d required none", m, ncyc);
                end else begin
                    e = exp_q.pop_front();
                    if (m != e.m || rd !== e.rd || ncyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL read_ack: got M%0d rd=%h cyc=%0d required M%0d rd=%h cyc=%0d",
                                 m, rd, ncyc, e.m, e.rd, e.cyc);
                    end
                end
                if (M1_ACK_OUT) M1_REQ_IN = 0;
            end
        end
        n_tests++;
        if (wr != 0) begin
            n_fail++;
            $display("FAIL read_no_write: strobes=%0d required 0", wr);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL read_ack_missing: %0d acks outstanding required 0", exp_q.size());
        end
        exp_q.delete();
        n_tests++;
        if (M1_READ_DATA_OUT !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL read_hold: rd1=%h required cafef00d", M1_READ_DATA_OUT);
        end
    endtask

    // Both masters request from reset; each keeps its request high until it
    // has been served rem[] times.
    task automatic test_contention();
        int start, m;
        int rem [2];
        logic [DW-1:0] rd;
        exp_t e;
        idle_inputs();
        RESET_IN = 1'b1;
        tick();
        RESET_IN = 1'b0;
        start = ncyc;
        M0_REQ_IN = 1; M0_ADDR_IN = 14'd1;
        M1_REQ_IN = 1; M1_ADDR_IN = 14'd3;
`ifdef REG_ARB_ROUND_ROBIN_EN
        rem[0] = 2; rem[1] = 2;
        exp_q.push_back('{0, 32'h11111111, start + 2});
        exp_q.push_back('{1, 32'h33333333, start + 5});
        exp_q.push_back('{0, 32'h11111111, start + 8});
        exp_q.push_back('{1, 32'h33333333, start + 11});
`else
        rem[0] = 2; rem[1] = 1;
        exp_q.push_back('{0, 32'h11111111, start + 2});
        exp_q.push_back('{0, 32'h11111111, start + 5});
        exp_q.push_back('{1, 32'h33333333, start + 8});
`endif
        for (int i = 0; i < 16; i++) begin
            tick();
            if (M0_ACK_OUT && M1_ACK_OUT) begin
                n_tests++;
                n_fail++;
                $display("FAIL contention_double_ack: both acks high at %0d required one", ncyc);
            end
            if (M0_ACK_OUT || M1_ACK_OUT) begin
                m = M1_ACK_OUT ? 1 : 0;
                rd = M1_ACK_OUT ? M1_READ_DATA_OUT : M0_READ_DATA_OUT;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL contention_ack: got M%0d ack at %0d required none", m, ncyc);
                end else begin
                    e = exp_q.pop_front();
                    if (m != e.m || rd !== e.rd || ncyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL contention_ack: got M%0d rd=%h cyc=%0d required M%0d rd=%h cyc=%0d",
                                 m, rd, ncyc, e.m, e.rd, e.cyc);
                    end
                end
                rem[m] = rem[m] - 1;
                if (rem[m] <= 0) begin
                    if (m == 0) M0_REQ_IN = 0;
                    else        M1_REQ_IN = 0;
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL contention_ack_missing: %0d acks outstanding required 0", exp_q.size());
        end
        exp_q.delete();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        M0_REQ_IN = 1; M0_WRITE_IN = 1; M0_ADDR_IN = 14'd3; M0_WRITE_DATA_IN = 32'hDEADBEEF;
        tick();   // ACCESS cycle
        RESET_IN = 1'b1;
        M0_REQ_IN = 0;
        tick();
        n_tests++;
        if ({M0_ACK_OUT, BUSY_OUT, WRITE_OUT} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_ctrl: ack0/busy/wr=%b required 000",
                     {M0_ACK_OUT, BUSY_OUT, WRITE_OUT});
        end
        n_tests++;
        if (M0_READ_DATA_OUT !== '0 || ADDR_OUT !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: rd0=%h addr=%h required 0/0", M0_READ_DATA_OUT, ADDR_OUT);
        end
        RESET_IN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (WRITE_OUT || M0_ACK_OUT || M1_ACK_OUT) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: %0d cycles with strobe/ack required 0", bad);
        end
    endtask

    task automatic test_mid_arrival();
        int start, m;
        logic [DW-1:0] rd;
        exp_t e;
        start = ncyc;
        M0_REQ_IN = 1; M0_WRITE_IN = 1; M0_ADDR_IN = 14'd1; M0_WRITE_DATA_IN = 32'hA5A5A5A5;
        exp_q.push_back('{0, 32'h11111111, start + 2});
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ncyc == start + 1) begin
                M1_REQ_IN = 1; M1_WRITE_IN = 0; M1_ADDR_IN = 14'd1;
                exp_q.push_back('{1, 32'hA5A5A5A5, start + 5});
            end
            if (M0_ACK_OUT || M1_ACK_OUT) begin
                m = M1_ACK_OUT ? 1 : 0;
                rd = M1_ACK_OUT ? M1_READ_DATA_OUT : M0_READ_DATA_OUT;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mid_ack: got M%0d ack at %0d required none", m, ncyc);
                end else begin
                    e = exp_q.pop_front();
                    if (m != e.m || rd !== e.rd || ncyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL mid_ack: got M%0d rd=%h cyc=%0d required M%0d rd=%h cyc=%0d",
                                 m, rd, ncyc, e.m, e.rd, e.cyc);
                    end
                end
                if (M0_ACK_OUT) M0_REQ_IN = 0;
                if (M1_ACK_OUT) M1_REQ_IN = 0;
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_ack_missing: %0d acks outstanding required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        RESET_IN = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_reset_mid();
        test_mid_arrival();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spinnaker_fpgas_reg_arbiter.md
SPINNAKER_FPGAS_REG_ARBITER -- requirements
Module: spinnaker_fpgas_reg_arbiter

Interface
REQ-001 SHALL have parameter REGA_BITS, default 14, register address width.
REQ-002 SHALL have parameter REGD_BITS, default 32, register data width.
REQ-003 SHALL have port CLK_IN  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RESET_IN  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports Mn_REQ_IN  input  1  access request from master n (n=0,1), held high until acknowledged.
REQ-006 SHALL have ports Mn_WRITE_IN  input  1  1=write, 0=read; held stable while Mn_REQ_IN is high.
REQ-007 SHALL have ports Mn_ADDR_IN  input  REGA_BITS  register address; held stable while Mn_REQ_IN is high.
REQ-008 SHALL have ports Mn_WRITE_DATA_IN  input  REGD_BITS  write data; held stable while Mn_REQ_IN is high.
REQ-009 SHALL have ports Mn_ACK_OUT  output  1  single-cycle completion pulse to master n.
REQ-010 SHALL have ports Mn_READ_DATA_OUT  output  REGD_BITS  read result for master n, valid while Mn_ACK_OUT is high and held until that master's next access.
REQ-011 SHALL have port WRITE_OUT  output  1  register-bank write strobe.
REQ-012 SHALL have port ADDR_OUT  output  REGA_BITS  register-bank address.
REQ-013 SHALL have port WRITE_DATA_OUT  output  REGD_BITS  register-bank write data.
REQ-014 SHALL have port READ_DATA_IN  input  REGD_BITS  combinational read data returned by the register bank for ADDR_OUT.
REQ-015 SHALL have port BUSY_OUT  output  1  high in every state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-017 SHALL stay in IDLE when no request is high.
REQ-018 SHALL, in IDLE with at least one request high, select one master, register its write flag, address and data, record the grant, and move to ACCESS.
REQ-019 SHALL, in ACCESS (exactly one cycle), drive ADDR_OUT and WRITE_DATA_OUT from the registered values, pulse WRITE_OUT high if the access is a write, and capture READ_DATA_IN into the granted master's read-data register for both reads and writes.
REQ-020 SHALL, in DONE (exactly one cycle), assert the granted master's Mn_ACK_OUT, then return to IDLE.
REQ-021 SHALL give an access latency of request-seen-in-IDLE to ACK of 2 cycles, and a throughput of 1 access per 3 cycles.
REQ-022 SHALL require a master to drop Mn_REQ_IN on the cycle after it sees its ACK; a request still high in IDLE is treated as a new access.
REQ-023 SHALL keep WRITE_OUT low outside ACCESS; ADDR_OUT and WRITE_DATA_OUT hold their last registered values.
REQ-024 SHALL resolve simultaneous requests using the arbitration policy in REQ-030/REQ-031.
REQ-025 SHALL ignore changes on request inputs while BUSY_OUT is high; a request arriving mid-access waits.
REQ-026 SHALL never assert both ACK outputs in the same cycle.

Reset
REQ-027 SHALL, on RESET_IN high at a clock edge, put the FSM in IDLE and force WRITE_OUT=0, both ACK outputs=0 and BUSY_OUT=0.
REQ-028 SHALL, on the same reset, clear ADDR_OUT, WRITE_DATA_OUT and both read-data outputs to 0, and set the last-granted pointer to master 1, so master 0 has first priority.
REQ-029 SHALL abandon any access in progress when reset is asserted mid-access: no ACK is issued and any pending WRITE_OUT is suppressed.

Configuration
REQ-030 SHALL, when macro REG_ARB_ROUND_ROBIN_EN is defined, grant the master other than the last-granted one when both request, updating the pointer on each grant.
REQ-031 SHALL, when REG_ARB_ROUND_ROBIN_EN is undefined, use fixed priority (master 0 always wins) and omit the last-granted pointer.

Verification
REQ-032 SHALL cover this case: reset, then M0 writes 0x12345678 to address 2 -> WRITE_OUT high for exactly one cycle with ADDR_OUT=2, and M0_ACK_OUT pulses 2 cycles after the request is seen.
REQ-033 SHALL cover this case: M1 reads address 0 while READ_DATA_IN=0xCAFEF00D -> M1_READ_DATA_OUT=0xCAFEF00D when M1_ACK_OUT pulses, and WRITE_OUT stays low.
REQ-034 SHALL cover this case: with REG_ARB_ROUND_ROBIN_EN defined, both masters request continuously from reset -> grants alternate M0, M1, M0, M1, with one ACK every 3 cycles.
REQ-035 SHALL cover this case: with REG_ARB_ROUND_ROBIN_EN undefined, both masters request and M0 re-requests straight after its ACK -> M0 is served twice before M1.
REQ-036 SHALL cover this case: RESET_IN asserted during ACCESS of an M0 write -> no M0_ACK_OUT, BUSY_OUT=0 on the next cycle, and the bank is not written after the reset.
REQ-037 SHALL cover this case: M1 requests while an M0 access is in ACCESS -> M1 is granted in the first IDLE cycle after M0's DONE.
